rec_tran: RTL and testbench
===========================

Name: rec_tran

Overview:
- Receive-side counterpart of the sender's transmit/retransmit logic.
- Deserializes the 8N1 serial OTN line at 16x baud, hunts for the FAS and captures one frame into a local buffer.
- Checks the frame's CRC-8, releases the payload on an AXIS-style byte stream toward the demapper/UART TX FIFO, and returns an ACK level to the sender.

Parameters:
- PYLD_BYTES, 16, payload bytes per frame (2..255).
- ACK_TICKS, 32, length of the ACK in i_sclk_en_16_x_baud ticks.
- FAS_B0, 8'hF6, first FAS byte.
- FAS_B1, 8'h28, second FAS byte.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset.
- i_sclk_en_16_x_baud  in  1  one-cycle enable at 16x baud.
- i_otn_rx_data  in  1  serial line from the sender (idle high).
- i_arq_en  in  1  ARQ mode switch.
- o_otn_tx_ack  out  1  ACK level back to the sender.
- o_pyld_data  out  8  payload byte.
- o_pyld_data_valid  out  1  payload byte valid.
- i_pyld_data_ready  in  1  downstream ready.
- o_crc_val  out  8  CRC byte received in the last frame.
- o_crc_err  out  1  one-cycle pulse on CRC mismatch.
- o_rt_state  out  3  FSM state encoding for LEDs.

Behaviour:
- Reset: i_rst is synchronous, active-high; clock is i_clk.
  - All outputs 0; state HUNT; buffer contents don't-care.
  - Deserializer returns to idle.
  - Reset mid-frame or mid-ACK aborts immediately.
- Deserializer:
  - i_otn_rx_data passes through a 2-flop synchronizer.
  - Start is a falling edge, confirmed low at tick 8.
  - Bits are sampled every 16 ticks, LSB first.
  - Stop bit sampled at 1: one-cycle byte strobe.
  - Stop bit sampled at 0: byte discarded, deserializer returns to idle.
- Frame format: FAS_B0, FAS_B1, PYLD_BYTES payload bytes, CRC byte.
- CRC: CRC-8, poly 0x07, init 0x00, MSB-first, computed over payload bytes only.
- FSM (o_rt_state encoding in brackets):
  - HUNT [0]: byte == FAS_B0 -> FAS2.
  - FAS2 [1]: byte == FAS_B1 -> PYLD, with cnt=0 and crc=0. Byte == FAS_B0 stays in FAS2. Any other byte -> HUNT.
  - PYLD [2]: stores buf[cnt] and updates crc. When cnt == PYLD_BYTES-1 -> CRCB.
  - CRCB [3]: on the CRC byte, latch o_crc_val and compare with the computed CRC.
    - i_arq_en=1, match -> DRAIN with ack_pend=1.
    - i_arq_en=1, mismatch -> o_crc_err pulse -> HUNT (frame dropped, no ACK; the sender times out and retransmits).
    - i_arq_en=0 -> DRAIN regardless of result, ack_pend=0. A mismatch still pulses o_crc_err.
  - DRAIN [4]:
    - o_pyld_data = buf[cnt], o_pyld_data_valid=1.
    - cnt advances on valid && ready; data and valid hold while ready=0.
    - After the last byte: ACK if ack_pend, else HUNT.
  - ACK [5]: o_otn_tx_ack=1 for exactly ACK_TICKS enable ticks, then 0 -> HUNT.
- Bytes arriving in DRAIN or ACK are discarded. Downstream must sustain ready so DRAIN (PYLD_BYTES cycles) finishes well inside one byte time.
- The byte counter width is $clog2(PYLD_BYTES+1) and never wraps past PYLD_BYTES-1.
- i_arq_en is sampled only in CRCB; changing it mid-frame has no other effect.
- Latency: first payload byte is valid 1 cycle after the CRC byte strobe.

Optional Feature:
- Macro: REC_TRAN_ERR_CNT_EN.
- Defined:
  - Adds o_err_cnt[7:0], which increments on each o_crc_err pulse and each stop-bit framing error.
  - The counter saturates at 8'hFF and clears on i_rst.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - state encodings (HUNT..ACK);
  - CRC8_POLY=8'h07 and CRC8_INIT=8'h00;
  - FAS byte constants;
  - the CRC-8 byte-update function, shared with the mapper.
- One sub-module: rec_uart_rx (synchronizer, 16x oversampler, byte strobe, framing-error flag).

Test Plan:
- ARQ on, FAS F6 28, 16 x 8'h00, CRC 8'h00:
  - 16 zero bytes on AXIS;
  - o_crc_val=8'h00;
  - o_otn_tx_ack high for 32 ticks;
  - no o_crc_err.
- ARQ on, same frame with CRC 8'h01:
  - o_crc_err pulses once;
  - zero AXIS bytes;
  - ack stays 0;
  - FSM back in HUNT.
- ARQ off, bad CRC 8'h01:
  - 16 bytes delivered;
  - o_crc_err pulses;
  - ack never asserted.
- Preamble 55 F6 F6 28 + good frame: locks at the second F6 and delivers payload 0x00..0x0F correctly (with matching CRC).
- ready held low 5 cycles mid-DRAIN: data/valid stable; no byte lost or duplicated; order preserved.
- i_rst asserted during PYLD byte 7, then a full good frame: only the second frame is delivered and ACKed.

Source files
------------

// File: rtl/rec_tran_pkg.sv
// ---------------------------------------------------------------------------
// rec_tran_pkg
// Shared definitions for the OTN receive path (rec_tran) and its UART
// deserializer (rec_uart_rx):
//   - rt_state_e : receive FSM encodings, also shown on the LEDs
//   - rx_state_e : deserializer phase encodings
//   - CRC-8 constants and the byte-wise CRC-8 update, shared with the mapper
//   - default FAS byte values
// ---------------------------------------------------------------------------
package rec_tran_pkg;

  typedef enum logic [2:0] {
    ST_HUNT  = 3'd0,
    ST_FAS2  = 3'd1,
    ST_PYLD  = 3'd2,
    ST_CRCB  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_ACK   = 3'd5
  } rt_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  localparam logic [7:0] CRC8_POLY   = 8'h07;
  localparam logic [7:0] CRC8_INIT   = 8'h00;
  localparam logic [7:0] FAS_B0_DFLT = 8'hF6;
  localparam logic [7:0] FAS_B1_DFLT = 8'h28;

  // CRC-8, MSB first: fold the whole byte in, then shift out 8 bits.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc_in,
                                             input logic [7:0] data_in);
    logic [7:0] c;
    c = crc_in ^ data_in;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) begin
        c = {c[6:0], 1'b0} ^ CRC8_POLY;
      end else begin
        c = {c[6:0], 1'b0};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/rec_uart_rx.sv
// ---------------------------------------------------------------------------
// rec_uart_rx
// 8N1 deserializer running on a 16x-baud enable.
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_sclk_en_16_x_baud   : one-cycle enable at 16x baud
//   i_rx                  : asynchronous serial line, idle high
//   o_byte                : last received byte (valid with o_byte_stb)
//   o_byte_stb            : one-cycle strobe, byte received with good stop bit
//   o_frame_err           : one-cycle strobe, stop bit sampled low (byte lost)
// ---------------------------------------------------------------------------
module rec_uart_rx
  import rec_tran_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sclk_en_16_x_baud,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_stb,
  output logic       o_frame_err
);

  logic      rx_meta_r;
  logic      rx_sync_r;
  logic      rx_last_r;
  rx_state_e state_r;
  rx_state_e state_nxt_s;
  logic [3:0] tick_cnt_r;
  logic [3:0] tick_cnt_nxt_s;
  logic [2:0] bit_idx_r;
  logic [2:0] bit_idx_nxt_s;
  logic [7:0] shift_r;
  logic [7:0] shift_nxt_s;
  logic       byte_stb_r;
  logic       byte_stb_nxt_s;
  logic       frame_err_r;
  logic       frame_err_nxt_s;

  // Two-flop synchronizer plus the line level seen at the previous tick.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_last_r <= 1'b1;
    end else begin
      rx_meta_r <= i_rx;
      rx_sync_r <= rx_meta_r;
      if (i_sclk_en_16_x_baud) begin
        rx_last_r <= rx_sync_r;
      end
    end
  end

  // Deserializer state, counters and output strobes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r     <= RX_IDLE;
      tick_cnt_r  <= 4'd0;
      bit_idx_r   <= 3'd0;
      shift_r     <= 8'h00;
      byte_stb_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      tick_cnt_r  <= tick_cnt_nxt_s;
      bit_idx_r   <= bit_idx_nxt_s;
      shift_r     <= shift_nxt_s;
      byte_stb_r  <= byte_stb_nxt_s;
      frame_err_r <= frame_err_nxt_s;
    end
  end

  // Next state: start detected on a falling edge between ticks, verified at
  // tick 8 (mid start bit), then every 16 ticks lands mid-bit.
  always_comb begin
    state_nxt_s    = state_r;
    tick_cnt_nxt_s = tick_cnt_r;
    bit_idx_nxt_s  = bit_idx_r;
    shift_nxt_s    = shift_r;
    if (i_sclk_en_16_x_baud) begin
      case (state_r)
        RX_IDLE: begin
          if (rx_last_r && !rx_sync_r) begin
            state_nxt_s    = RX_START;
            tick_cnt_nxt_s = 4'd0;
          end else begin
            state_nxt_s    = RX_IDLE;
          end
        end
        RX_START: begin
          if (tick_cnt_r == 4'd7) begin
            tick_cnt_nxt_s = 4'd0;
            bit_idx_nxt_s  = 3'd0;
            if (!rx_sync_r) begin
              state_nxt_s = RX_DATA;
            end else begin
              state_nxt_s = RX_IDLE;
            end
          end else begin
            tick_cnt_nxt_s = tick_cnt_r + 4'd1;
          end
        end
        RX_DATA: begin
          if (tick_cnt_r == 4'd15) begin
            tick_cnt_nxt_s = 4'd0;
            shift_nxt_s    = {rx_sync_r, shift_r[7:1]};
            if (bit_idx_r == 3'd7) begin
              state_nxt_s = RX_STOP;
            end else begin
              bit_idx_nxt_s = bit_idx_r + 3'd1;
            end
          end else begin
            tick_cnt_nxt_s = tick_cnt_r + 4'd1;
          end
        end
        RX_STOP: begin
          if (tick_cnt_r == 4'd15) begin
            tick_cnt_nxt_s = 4'd0;
            state_nxt_s    = RX_IDLE;
          end else begin
            tick_cnt_nxt_s = tick_cnt_r + 4'd1;
          end
        end
        default: begin
          state_nxt_s    = RX_IDLE;
          tick_cnt_nxt_s = 4'd0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Output strobes decided at the mid-stop-bit sample.
  always_comb begin
    byte_stb_nxt_s  = 1'b0;
    frame_err_nxt_s = 1'b0;
    if (i_sclk_en_16_x_baud && (state_r == RX_STOP) && (tick_cnt_r == 4'd15)) begin
      byte_stb_nxt_s  = rx_sync_r;
      frame_err_nxt_s = !rx_sync_r;
    end else begin
      byte_stb_nxt_s  = 1'b0;
      frame_err_nxt_s = 1'b0;
    end
  end

  assign o_byte      = shift_r;
  assign o_byte_stb  = byte_stb_r;
  assign o_frame_err = frame_err_r;

endmodule

// File: rtl/rec_tran.sv
// ---------------------------------------------------------------------------
// rec_tran
// Receive side of the OTN ARQ link: deserializes the 8N1 line, hunts for the
// FAS, buffers one frame, checks its CRC-8, streams the payload out on an
// AXIS-style byte interface and returns an ACK level to the sender.
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_sclk_en_16_x_baud   : one-cycle enable at 16x baud
//   i_otn_rx_data         : serial line from the sender (idle high)
//   i_arq_en              : ARQ mode, sampled only when the CRC byte arrives
//   o_otn_tx_ack          : ACK level, high for ACK_TICKS enable ticks
//   o_pyld_data/_valid    : payload byte stream, i_pyld_data_ready handshake
//   o_crc_val             : CRC byte carried by the last frame
//   o_crc_err             : one-cycle pulse on CRC mismatch
//   o_rt_state            : FSM state for LEDs
// Build option REC_TRAN_ERR_CNT_EN adds o_err_cnt, a saturating count of CRC
// errors and stop-bit framing errors.
// ---------------------------------------------------------------------------
module rec_tran
  import rec_tran_pkg::*;
#(
  parameter int         PYLD_BYTES = 16,
  parameter int         ACK_TICKS  = 32,
  parameter logic [7:0] FAS_B0     = FAS_B0_DFLT,
  parameter logic [7:0] FAS_B1     = FAS_B1_DFLT
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sclk_en_16_x_baud,
  input  logic       i_otn_rx_data,
  input  logic       i_arq_en,
  output logic       o_otn_tx_ack,
  output logic [7:0] o_pyld_data,
  output logic       o_pyld_data_valid,
  input  logic       i_pyld_data_ready,
  output logic [7:0] o_crc_val,
  output logic       o_crc_err,
`ifdef REC_TRAN_ERR_CNT_EN
  output logic [7:0] o_err_cnt,
`endif
  output logic [2:0] o_rt_state
);

  localparam int CNT_W = $clog2(PYLD_BYTES + 1);
  localparam int IDX_W = (PYLD_BYTES > 1) ? $clog2(PYLD_BYTES) : 1;
  localparam int ACK_W = $clog2(ACK_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PYLD_BYTES - 1);
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TICKS - 1);

  logic [7:0] rx_byte_s;
  logic       rx_stb_s;
  logic       rx_ferr_s;

  rt_state_e        state_r;
  rt_state_e        state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [7:0]       crc_r;
  logic [7:0]       crc_nxt_s;
  logic             ack_pend_r;
  logic             ack_pend_nxt_s;
  logic [ACK_W-1:0] ack_cnt_r;
  logic [ACK_W-1:0] ack_cnt_nxt_s;
  logic             buf_we_s;
  logic [7:0]       buf_r [PYLD_BYTES];
  logic             drain_hs_s;

  logic [7:0] pyld_data_r;
  logic [7:0] pyld_data_nxt_s;
  logic       pyld_valid_r;
  logic       pyld_valid_nxt_s;
  logic       ack_r;
  logic       ack_nxt_s;
  logic [7:0] crc_val_r;
  logic [7:0] crc_val_nxt_s;
  logic       crc_err_r;
  logic       crc_err_nxt_s;
  logic [2:0] rt_state_r;

  rec_uart_rx u_rx (
    .i_clk               (i_clk),
    .i_rst               (i_rst),
    .i_sclk_en_16_x_baud (i_sclk_en_16_x_baud),
    .i_rx                (i_otn_rx_data),
    .o_byte              (rx_byte_s),
    .o_byte_stb          (rx_stb_s),
    .o_frame_err         (rx_ferr_s)
  );

  assign drain_hs_s = pyld_valid_r && i_pyld_data_ready;

  // FSM state and frame datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r    <= ST_HUNT;
      cnt_r      <= {CNT_W{1'b0}};
      crc_r      <= CRC8_INIT;
      ack_pend_r <= 1'b0;
      ack_cnt_r  <= {ACK_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      crc_r      <= crc_nxt_s;
      ack_pend_r <= ack_pend_nxt_s;
      ack_cnt_r  <= ack_cnt_nxt_s;
    end
  end

  // Payload buffer; contents are don't-care after reset.
  always_ff @(posedge i_clk) begin
    if (buf_we_s) begin
      buf_r[cnt_r[IDX_W-1:0]] <= rx_byte_s;
    end
  end

  // Next state. Bytes arriving in DRAIN/ACK are simply ignored.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    crc_nxt_s      = crc_r;
    ack_pend_nxt_s = ack_pend_r;
    ack_cnt_nxt_s  = ack_cnt_r;
    buf_we_s       = 1'b0;
    crc_err_nxt_s  = 1'b0;
    crc_val_nxt_s  = crc_val_r;
    case (state_r)
      ST_HUNT: begin
        if (rx_stb_s && (rx_byte_s == FAS_B0)) begin
          state_nxt_s = ST_FAS2;
        end else begin
          state_nxt_s = ST_HUNT;
        end
      end
      ST_FAS2: begin
        if (rx_stb_s) begin
          if (rx_byte_s == FAS_B1) begin
            state_nxt_s = ST_PYLD;
            cnt_nxt_s   = {CNT_W{1'b0}};
            crc_nxt_s   = CRC8_INIT;
          end else if (rx_byte_s == FAS_B0) begin
            state_nxt_s = ST_FAS2;  // repeated FAS_B0 may be the real start
          end else begin
            state_nxt_s = ST_HUNT;
          end
        end else begin
          state_nxt_s = ST_FAS2;
        end
      end
      ST_PYLD: begin
        if (rx_stb_s) begin
          buf_we_s  = 1'b1;
          crc_nxt_s = crc8_update(crc_r, rx_byte_s);
          if (cnt_r == CNT_LAST) begin
            state_nxt_s = ST_CRCB;
            cnt_nxt_s   = {CNT_W{1'b0}};
          end else begin
            cnt_nxt_s   = cnt_r + CNT_W'(1);
          end
        end else begin
          state_nxt_s = ST_PYLD;
        end
      end
      ST_CRCB: begin
        if (rx_stb_s) begin
          crc_val_nxt_s = rx_byte_s;
          cnt_nxt_s     = {CNT_W{1'b0}};
          crc_err_nxt_s = (rx_byte_s != crc_r);
          if (i_arq_en) begin
            // With ARQ a bad frame is dropped silently; the sender times out.
            if (rx_byte_s == crc_r) begin
              state_nxt_s    = ST_DRAIN;
              ack_pend_nxt_s = 1'b1;
            end else begin
              state_nxt_s    = ST_HUNT;
              ack_pend_nxt_s = 1'b0;
            end
          end else begin
            state_nxt_s    = ST_DRAIN;
            ack_pend_nxt_s = 1'b0;
          end
        end else begin
          state_nxt_s = ST_CRCB;
        end
      end
      ST_DRAIN: begin
        if (drain_hs_s) begin
          if (cnt_r == CNT_LAST) begin
            ack_cnt_nxt_s = {ACK_W{1'b0}};
            if (ack_pend_r) begin
              state_nxt_s = ST_ACK;
            end else begin
              state_nxt_s = ST_HUNT;
            end
          end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_ACK: begin
        if (i_sclk_en_16_x_baud) begin
          if (ack_cnt_r == ACK_LAST) begin
            state_nxt_s = ST_HUNT;
          end else begin
            ack_cnt_nxt_s = ack_cnt_r + ACK_W'(1);
          end
        end else begin
          state_nxt_s = ST_ACK;
        end
      end
      default: begin
        state_nxt_s = ST_HUNT;
      end
    endcase
  end

  // Registered-output values derived from the upcoming state, so the first
  // payload byte is presented the cycle after the CRC byte strobe.
  always_comb begin
    pyld_valid_nxt_s = (state_nxt_s == ST_DRAIN);
    ack_nxt_s        = (state_nxt_s == ST_ACK);
    if (state_nxt_s == ST_DRAIN) begin
      pyld_data_nxt_s = buf_r[cnt_nxt_s[IDX_W-1:0]];
    end else begin
      pyld_data_nxt_s = 8'h00;
    end
  end

  // Output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pyld_data_r  <= 8'h00;
      pyld_valid_r <= 1'b0;
      ack_r        <= 1'b0;
      crc_val_r    <= 8'h00;
      crc_err_r    <= 1'b0;
      rt_state_r   <= 3'd0;
    end else begin
      pyld_data_r  <= pyld_data_nxt_s;
      pyld_valid_r <= pyld_valid_nxt_s;
      ack_r        <= ack_nxt_s;
      crc_val_r    <= crc_val_nxt_s;
      crc_err_r    <= crc_err_nxt_s;
      rt_state_r   <= state_nxt_s;
    end
  end

`ifdef REC_TRAN_ERR_CNT_EN
  logic [7:0] err_cnt_r;

  // Saturating count of CRC errors and stop-bit framing errors.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      err_cnt_r <= 8'h00;
    end else if ((crc_err_nxt_s || rx_ferr_s) && (err_cnt_r != 8'hFF)) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end
  end

  assign o_err_cnt = err_cnt_r;
`else
  // Framing errors only feed the optional error counter.
  logic unused_ferr_s;
  assign unused_ferr_s = rx_ferr_s;
`endif

  assign o_otn_tx_ack      = ack_r;
  assign o_pyld_data       = pyld_data_r;
  assign o_pyld_data_valid = pyld_valid_r;
  assign o_crc_val         = crc_val_r;
  assign o_crc_err         = crc_err_r;
  assign o_rt_state        = rt_state_r;

endmodule

// File: tb/tb_rec_tran.sv
// ---------------------------------------------------------------------------
// tb_rec_tran
// Directed frames driven on the serial line; expected payload bytes are
// queued when a frame is issued and a monitor process pops/compares them on
// every AXIS handshake. Per-test CRC-error pulses and ACK ticks are counted
// by the monitor and compared at the end of each test.
// ---------------------------------------------------------------------------
module tb_rec_tran;

  localparam int PB       = 16;
  localparam int AT       = 32;
  localparam int BIT_CLKS = 32;  // 16 enable ticks, one every 2 clocks

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk_en = 1'b0;
  logic       rx = 1'b1;
  logic       arq_en = 1'b1;
  logic       rdy = 1'b1;
  logic       ack;
  logic [7:0] data;
  logic       valid;
  logic [7:0] crc_val;
  logic       crc_err;
  logic [2:0] rt_state;
`ifdef REC_TRAN_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int err_pulses = 0;
  int ack_ticks = 0;
  int ack_cycles = 0;
  logic [7:0] exp_q [$];
  logic [7:0] pl [PB];

  rec_tran #(.PYLD_BYTES(PB), .ACK_TICKS(AT)) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_sclk_en_16_x_baud (sclk_en),
    .i_otn_rx_data       (rx),
    .i_arq_en            (arq_en),
    .o_otn_tx_ack        (ack),
    .o_pyld_data         (data),
    .o_pyld_data_valid   (valid),
    .i_pyld_data_ready   (rdy),
    .o_crc_val           (crc_val),
    .o_crc_err           (crc_err),
`ifdef REC_TRAN_ERR_CNT_EN
    .o_err_cnt           (err_cnt),
`endif
    .o_rt_state          (rt_state)
  );

  always #5 clk = ~clk;

  // 16x-baud enable: every other clock
  initial begin
    forever begin
      @(posedge clk);
      #1;
      sclk_en = ~sclk_en;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bit-serial reference CRC-8 (poly 0x07, MSB first)
  function automatic logic [7:0] crc_model(input logic [7:0] c_in, input logic [7:0] d);
    logic [7:0] c;
    logic fb;
    c = c_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  function automatic logic [7:0] frame_crc();
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < PB; i++) c = crc_model(c, pl[i]);
    return c;
  endfunction

  // Monitor / scoreboard
  initial begin
    logic       prev_hold;
    logic [7:0] prev_data;
    prev_hold = 1'b0;
    prev_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (prev_hold) begin
          check("hold_valid", {31'd0, valid}, 32'd1);
          check("hold_data", {24'd0, data}, {24'd0, prev_data});
        end
        if (valid && rdy) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %02h, none expected", data);
          end else begin
            check("pyld_byte", {24'd0, data}, {24'd0, exp_q.pop_front()});
          end
        end
        if (crc_err) err_pulses++;
        if (ack) ack_cycles++;
        if (ack && sclk_en) ack_ticks++;
        prev_hold = valid && !rdy;
        prev_data = data;
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  task automatic send_bit(input logic v);
    rx = v;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] crc);
    send_byte(8'hF6);
    send_byte(8'h28);
    for (int i = 0; i < PB; i++) send_byte(pl[i]);
    send_byte(crc);
  endtask

  task automatic fill(input logic [7:0] base, input logic [7:0] step);
    for (int i = 0; i < PB; i++) pl[i] = base + step * 8'(i);
  endtask

  task automatic push_expected();
    for (int i = 0; i < PB; i++) exp_q.push_back(pl[i]);
  endtask

  task automatic start_test();
    err_pulses = 0;
    ack_ticks  = 0;
    ack_cycles = 0;
  endtask

  task automatic end_test(input string name, input int exp_err, input int exp_ack,
                          input logic [7:0] exp_crc);
    repeat (400) @(posedge clk);
    #1;
    check({name, "_bytes_left"}, exp_q.size(), 32'd0);
    exp_q.delete();
    check({name, "_crc_err_pulses"}, err_pulses, exp_err);
    check({name, "_ack_ticks"}, ack_ticks, exp_ack);
    if (exp_ack == 0) check({name, "_ack_cycles"}, ack_cycles, 32'd0);
    check({name, "_crc_val"}, {24'd0, crc_val}, {24'd0, exp_crc});
    check({name, "_state_hunt"}, {29'd0, rt_state}, 32'd0);
  endtask

  initial begin
    logic [7:0] c;
    int n;
    // reset state
    repeat (5) @(posedge clk);
    #1;
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_data", {24'd0, data}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_crc_val", {24'd0, crc_val}, 32'd0);
    check("rst_crc_err", {31'd0, crc_err}, 32'd0);
    check("rst_state", {29'd0, rt_state}, 32'd0);
    rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;

    // T1: ARQ on, zero payload, good CRC 00
    start_test();
    arq_en = 1'b1;
    fill(8'h00, 8'h00);
    push_expected();
    send_frame(8'h00);
    end_test("t1", 0, AT, 8'h00);

    // T2: ARQ on, bad CRC 01 -> dropped, no ACK
    start_test();
    send_frame(8'h01);
    end_test("t2", 1, 0, 8'h01);

    // T3: ARQ off, bad CRC -> delivered, error pulse, no ACK
    start_test();
    arq_en = 1'b0;
    push_expected();
    send_frame(8'h01);
    end_test("t3", 1, 0, 8'h01);

    // T4: preamble 55 F6 then F6 28 + payload 00..0F
    start_test();
    arq_en = 1'b1;
    fill(8'h00, 8'h01);
    c = frame_crc();
    push_expected();
    send_byte(8'h55);
    send_byte(8'hF6);
    send_frame(c);
    end_test("t4", 0, AT, c);

    // T5: ready held low 5 cycles mid-drain
    start_test();
    fill(8'hA0, 8'h03);
    c = frame_crc();
    push_expected();
    fork
      send_frame(c);
      begin
        n = 0;
        while (!valid && n < 20000) begin
          @(negedge clk);
          n++;
        end
        check("t5_valid_seen", {31'd0, valid}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        rdy = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rdy = 1'b1;
      end
    join
    end_test("t5", 0, AT, c);
`ifdef REC_TRAN_ERR_CNT_EN
    check("err_cnt", {24'd0, err_cnt}, 32'd2);
`endif

    // T6: reset during payload byte 7, then a full good frame
    start_test();
    fill(8'h30, 8'h01);
    send_byte(8'hF6);
    send_byte(8'h28);
    for (int i = 0; i < 7; i++) send_byte(pl[i]);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst = 1'b1;
    rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("t6_rst_state", {29'd0, rt_state}, 32'd0);
    check("t6_rst_valid", {31'd0, valid}, 32'd0);
    rst = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    start_test();
    c = frame_crc();
    push_expected();
    send_frame(c);
    end_test("t6", 0, AT, c);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
